load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_align.sv | 61 ++++++
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg : shared funct3 width codes, FSM state type and address helpers
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic f3_is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return (f3_is_half(f3) && off[0]) || ((f3 == F3_W) && (off != 2'b00));
    endfunction

    // Clears the low offset bits a half or word access cannot legally use
    function automatic logic [1:0] fix_offset(input logic [2:0] f3, input logic [1:0] off);
        if (f3 == F3_W)
            return 2'b00;
        else if (f3_is_half(f3))
            return {off[1], 1'b0};
        else
            return off;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// lsu_align : store lane/byte-enable generation and load lane extraction
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_lanes,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        st_be    = 4'b1111;
        st_lanes = st_wdata;
        case (st_funct3)
            F3_B: begin
                st_be    = 4'b0001 << st_off;
                st_lanes = {4{st_wdata[7:0]}};
            end
            F3_H: begin
                st_be    = st_off[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_lanes = st_wdata;
            end
        endcase
    end

    assign w_shifted = ld_word >> {ld_off, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        ld_data = ld_word;
        case (ld_funct3)
            F3_B:    ld_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   ld_data = {24'h0, w_byte};
            F3_H:    ld_data = {{16{w_half[15]}}, w_half};
            F3_HU:   ld_data = {16'h0, w_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : RV32I load/store bus master with wait-timeout abort.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of
// silently aligning them.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_funct3,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    lsu_state_t  state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic        cpu_err_q, cpu_err_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;

    logic        w_misalign;
    logic [1:0]  w_off;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_lanes;
    logic [31:0] w_ld_data;
    logic [7:0]  w_cnt_inc;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = is_misaligned(cpu_funct3, cpu_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_off     = fix_offset(cpu_funct3, cpu_addr[1:0]);
    assign w_cnt_inc = cnt_q + 8'd1;

    // Store lanes come from the live request; load extraction from the captured one
    lsu_align u_align (
        .st_funct3 (cpu_funct3),
        .st_off    (w_off),
        .st_wdata  (cpu_wdata),
        .st_be     (w_st_be),
        .st_lanes  (w_st_lanes),
        .ld_funct3 (funct3_q),
        .ld_off    (off_q),
        .ld_word   (mem_rdata),
        .ld_data   (w_ld_data)
    );

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        cpu_ready_d = 1'b0;
        cpu_err_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_valid) begin
                    funct3_d = cpu_funct3;
                    off_d    = w_off;
                    if (!f3_legal(cpu_funct3) || w_misalign) begin
                        state_d     = ST_RESP;
                        cpu_ready_d = 1'b1;
                        cpu_err_d   = 1'b1;
                        cpu_rdata_d = 32'h0;
                    end else begin
                        state_d     = ST_REQ;
                        cnt_d       = 8'h0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = cpu_we;
                        mem_addr_d  = {cpu_addr[31:2], 2'b00};
                        mem_wdata_d = cpu_we ? w_st_lanes : 32'h0;
                        mem_be_d    = cpu_we ? w_st_be : 4'b1111;
                    end
                end
            end
            ST_REQ: begin
                // An ack in the timeout cycle still completes the access normally
                if (mem_ack) begin
                    state_d     = ST_RESP;
                    mem_req_d   = 1'b0;
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = mem_we_q ? 32'h0 : w_ld_data;
                end else if (w_cnt_inc == WAIT_LIMIT) begin
                    state_d     = ST_RESP;
                    cnt_d       = w_cnt_inc;
                    mem_req_d   = 1'b0;
                    cpu_ready_d = 1'b1;
                    cpu_err_d   = 1'b1;
                    cpu_rdata_d = 32'h0;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            cnt_q       <= 8'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'b0000;
            cpu_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign stall     = cpu_valid && !cpu_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

`default_nettype wire
